// File: rtl/pong_pkg.sv
// Shared geometry, timing constants and state encoding for the pong ball
// controller and its neighbours.
package pong_pkg;

  localparam logic [9:0] FIELD_W     = 10'd640;
  localparam logic [9:0] FIELD_H     = 10'd480;
  localparam logic [9:0] BALL_SIZE   = 10'd8;
  localparam logic [9:0] HALF_BALL   = BALL_SIZE >> 1;
  localparam logic [9:0] PADDLE_W    = 10'd8;
  localparam logic [9:0] PADDLE_H    = 10'd64;
  localparam logic [9:0] HALF_PADDLE = PADDLE_H >> 1;
  localparam logic [9:0] PADDLE_L_X  = 10'd16;
  localparam logic [9:0] PADDLE_R_X  = 10'd616;

  // Ball x where its edge touches the inner face of each paddle.
  localparam logic [9:0] HIT_L_X = PADDLE_L_X + PADDLE_W;
  localparam logic [9:0] HIT_R_X = PADDLE_R_X - BALL_SIZE;

  localparam logic [9:0] MAX_X    = FIELD_W - BALL_SIZE;
  localparam logic [9:0] MAX_Y    = FIELD_H - BALL_SIZE;
  localparam logic [9:0] CENTRE_X = (FIELD_W - BALL_SIZE) >> 1;
  localparam logic [9:0] CENTRE_Y = (FIELD_H - BALL_SIZE) >> 1;

  localparam logic signed [2:0] SPEED_POS = 3'sd2;
  localparam logic signed [2:0] SPEED_NEG = -3'sd2;

  localparam logic [5:0] HOLD_FRAMES = 6'd60;
  localparam logic [3:0] WIN_SCORE   = 4'd9;

  typedef enum logic [1:0] {
    ST_SERVE_WAIT = 2'd0,
    ST_PLAY       = 2'd1,
    ST_SCORED     = 2'd2,
    ST_GAME_OVER  = 2'd3
  } state_e;

  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

  function automatic logic signed [10:0] to_s11(input logic [9:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic signed [10:0] sext_v(input logic signed [2:0] v);
    return {{8{v[2]}}, v};
  endfunction

endpackage

// File: rtl/score_counter.sv
// Four-bit point counter that stops at the winning score.
module score_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] count
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q < WIN_SCORE)) count_d = count_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/ball_ctrl.sv
// Ball motion, paddle collision and scoring for a two-player pong field.
// Motion advances once per frame_tick; serve is the only cycle-rate event.
//
// state         | meaning
// ST_SERVE_WAIT | ball parked at centre, waiting for serve
// ST_PLAY       | ball moving; walls, paddles and misses evaluated per frame
// ST_SCORED     | ball parked, hold counter running down before next serve
// ST_GAME_OVER  | a player reached the winning score; held until reset
module ball_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       serve,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       point_l,
  output logic       point_r,
  output logic       game_over
);

  state_e            state_q, state_d;
  logic [9:0]        ball_x_q, ball_x_d;
  logic [9:0]        ball_y_q, ball_y_d;
  logic signed [2:0] vx_q, vx_d;
  logic signed [2:0] vy_q, vy_d;
  logic [5:0]        hold_q, hold_d;
  logic              point_l_q, point_l_d;
  logic              point_r_q, point_r_d;

  logic signed [10:0] nx, ny;
  logic               hit_l, hit_r, wall_y;

  function automatic logic overlap(input logic [9:0] by, input logic [9:0] py);
    return (ext11(by) + ext11(BALL_SIZE) > ext11(py)) &&
           (ext11(by) < ext11(py) + ext11(PADDLE_H));
  endfunction

  // Upper half of the paddle sends the ball up, lower half sends it down.
  function automatic logic signed [2:0] aim_vy(input logic [9:0] by, input logic [9:0] py);
    return (ext11(by) + ext11(HALF_BALL) < ext11(py) + ext11(HALF_PADDLE)) ? SPEED_NEG : SPEED_POS;
  endfunction

  always_comb begin
    nx     = to_s11(ball_x_q) + sext_v(vx_q);
    ny     = to_s11(ball_y_q) + sext_v(vy_q);
    wall_y = (ny <= 11'sd0) || (ny >= to_s11(MAX_Y));
    hit_l  = (vx_q < 3'sd0) && (ball_x_q >= HIT_L_X) && (nx <= to_s11(HIT_L_X)) &&
             overlap(ball_y_q, paddle_l_y);
    hit_r  = (vx_q > 3'sd0) && (ball_x_q <= HIT_R_X) && (nx >= to_s11(HIT_R_X)) &&
             overlap(ball_y_q, paddle_r_y);
  end

  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    hold_d    = hold_q;
    point_l_d = 1'b0;
    point_r_d = 1'b0;

    case (state_q)
      ST_SERVE_WAIT: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
        if (serve) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (ny <= 11'sd0) begin
            ball_y_d = '0;
            vy_d     = SPEED_POS;
          end else if (ny >= to_s11(MAX_Y)) begin
            ball_y_d = MAX_Y;
            vy_d     = SPEED_NEG;
          end else begin
            ball_y_d = ny[9:0];
          end

          // In a corner the wall owns vy so the ball cannot be aimed off-field.
          if (hit_l) begin
            ball_x_d = HIT_L_X;
            vx_d     = SPEED_POS;
            if (!wall_y) vy_d = aim_vy(ball_y_q, paddle_l_y);
          end else if (hit_r) begin
            ball_x_d = HIT_R_X;
            vx_d     = SPEED_NEG;
            if (!wall_y) vy_d = aim_vy(ball_y_q, paddle_r_y);
          end else if (nx <= 11'sd0) begin
            point_r_d = 1'b1;
            vx_d      = SPEED_NEG;
            ball_x_d  = CENTRE_X;
            ball_y_d  = CENTRE_Y;
            hold_d    = HOLD_FRAMES;
            state_d   = ST_SCORED;
          end else if (nx >= to_s11(MAX_X)) begin
            point_l_d = 1'b1;
            vx_d      = SPEED_POS;
            ball_x_d  = CENTRE_X;
            ball_y_d  = CENTRE_Y;
            hold_d    = HOLD_FRAMES;
            state_d   = ST_SCORED;
          end else begin
            ball_x_d = nx[9:0];
          end
        end
      end

      ST_SCORED: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
        if (frame_tick) begin
          if (hold_q <= 6'd1) begin
            hold_d  = '0;
            state_d = ((score_l == WIN_SCORE) || (score_r == WIN_SCORE)) ? ST_GAME_OVER
                                                                          : ST_SERVE_WAIT;
          end else begin
            hold_d = hold_q - 6'd1;
          end
        end
      end

      ST_GAME_OVER: begin
        ball_x_d = CENTRE_X;
        ball_y_d = CENTRE_Y;
      end

      default: state_d = ST_SERVE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SERVE_WAIT;
      ball_x_q  <= CENTRE_X;
      ball_y_q  <= CENTRE_Y;
      vx_q      <= SPEED_POS;
      vy_q      <= SPEED_POS;
      hold_q    <= '0;
      point_l_q <= 1'b0;
      point_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      hold_q    <= hold_d;
      point_l_q <= point_l_d;
      point_r_q <= point_r_d;
    end
  end

  score_counter u_score_l (
    .clk   (clk),
    .reset (reset),
    .inc   (point_l_d),
    .count (score_l)
  );

  score_counter u_score_r (
    .clk   (clk),
    .reset (reset),
    .inc   (point_r_d),
    .count (score_r)
  );

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign point_l   = point_l_q;
  assign point_r   = point_r_q;
  assign game_over = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_ball_ctrl.sv
// Randomised bench for ball_ctrl: a game-level reference model predicts the
// visible outputs per cycle into a queue that a separate monitor drains.
module tb_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] paddle_l_y = '0;
  logic [9:0] paddle_r_y = '0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score_l, score_r;
  logic       point_l, point_r, game_over;

  always #5 clk = ~clk;

  ball_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .serve      (serve),
    .paddle_l_y (paddle_l_y),
    .paddle_r_y (paddle_r_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .point_l    (point_l),
    .point_r    (point_r),
    .game_over  (game_over)
  );

  typedef struct {
    int bx; int by; int sl; int sr; int pl; int pr; int go;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Game-level model: mode, position, velocity, scores, frames left in hold.
  localparam int M_WAIT = 0, M_PLAY = 1, M_SCORED = 2, M_OVER = 3;
  int m_mode, m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_hold, m_ptl, m_ptr;

  task automatic model_step(input bit rst, input bit fr, input bit sv, input int pl, input int pr);
    int nx, ny, tx, ty;
    bit wall, scored, hitl, hitr;
    m_ptl = 0;
    m_ptr = 0;
    if (rst) begin
      m_mode = M_WAIT; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 2;
      m_sl = 0; m_sr = 0; m_hold = 0;
      return;
    end
    case (m_mode)
      M_WAIT: if (sv) m_mode = M_PLAY;
      M_PLAY: if (fr) begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        wall = 1; scored = 0; tx = m_bx;
        if (ny <= 0) begin ty = 0; m_vy = 2; end
        else if (ny >= 472) begin ty = 472; m_vy = -2; end
        else begin ty = ny; wall = 0; end
        hitl = (m_vx < 0) && (m_bx >= 24) && (nx <= 24) && (m_by + 8 > pl) && (m_by < pl + 64);
        hitr = (m_vx > 0) && (m_bx <= 608) && (nx >= 608) && (m_by + 8 > pr) && (m_by < pr + 64);
        if (hitl || hitr) begin
          tx   = hitl ? 24 : 608;
          m_vx = hitl ? 2 : -2;
          if (!wall) m_vy = (m_by + 4 < (hitl ? pl : pr) + 32) ? -2 : 2;
        end else if (nx <= 0) begin
          scored = 1; m_ptr = 1; m_vx = -2;
          if (m_sr < 9) m_sr++;
        end else if (nx >= 632) begin
          scored = 1; m_ptl = 1; m_vx = 2;
          if (m_sl < 9) m_sl++;
        end else begin
          tx = nx;
        end
        if (scored) begin
          m_bx = 316; m_by = 236; m_mode = M_SCORED; m_hold = 60;
        end else begin
          m_bx = tx; m_by = ty;
        end
      end
      M_SCORED: if (fr) begin
        m_hold--;
        if (m_hold == 0) m_mode = (m_sl == 9 || m_sr == 9) ? M_OVER : M_WAIT;
      end
      default: ;
    endcase
  endtask

  task automatic cycle(input bit rst, input bit fr, input bit sv, input int pl, input int pr);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    frame_tick = fr;
    serve      = sv;
    paddle_l_y = 10'(pl);
    paddle_r_y = 10'(pr);
    model_step(rst, fr, sv, pl, pr);
    e = '{m_bx, m_by, m_sl, m_sr, m_ptl, m_ptr, (m_mode == M_OVER) ? 1 : 0};
    exp_q.push_back(e);
  endtask

  function automatic int pick_paddle(input int by);
    int off;
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 1023));
    off = int'($urandom_range(0, 70));
    return (by >= off) ? by - off : 0;
  endfunction

  // Monitor: every cycle the DUT presents a fresh output tuple.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (ball_x !== 10'(e.bx) || ball_y !== 10'(e.by) || score_l !== 4'(e.sl) ||
            score_r !== 4'(e.sr) || point_l !== 1'(e.pl) || point_r !== 1'(e.pr) ||
            game_over !== 1'(e.go)) begin
          n_bad++;
          $display("FAIL outputs t=%0t got x=%0d y=%0d sl=%0d sr=%0d pl=%0b pr=%0b go=%0b want x=%0d y=%0d sl=%0d sr=%0d pl=%0d pr=%0d go=%0d",
                   $time, ball_x, ball_y, score_l, score_r, point_l, point_r, game_over,
                   e.bx, e.by, e.sl, e.sr, e.pl, e.pr, e.go);
        end
      end
    end
  end

  initial begin
    int guard;
    repeat (3) cycle(1, 0, 0, 0, 0);

    // Serve then a single frame: first step lands at (318,238).
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);

    // Random rallies with paddles mostly tracking the ball.
    for (int i = 0; i < 6000; i++) begin
      bit r, f, s;
      r = ($urandom_range(0, 799) == 0);
      f = ($urandom_range(0, 1) == 0);
      s = ($urandom_range(0, 15) == 0);
      cycle(r, f, s, pick_paddle(m_by), pick_paddle(m_by));
    end

    // Left player wins every point until the game ends.
    cycle(1, 0, 0, 0, 0);
    guard = 0;
    while (m_mode != M_OVER && guard < 9000) begin
      cycle(0, (guard % 2) == 0, $urandom_range(0, 3) == 0, 600, 700);
      guard++;
    end
    if (m_mode != M_OVER) begin
      n_bad++;
      $display("FAIL game_end_timeout got no game over within %0d cycles want game over", guard);
    end
    for (int i = 0; i < 200; i++)
      cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pick_paddle(m_by), 700);
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Right paddle always returns, left always misses: right scores and the
    // next serve must head left.
    for (int i = 0; i < 2500; i++)
      cycle(0, 1'b1, $urandom_range(0, 3) == 0, 1000, m_by);

    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clk);
      #3;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 frame_tick  input  1  one-cycle pulse, once per video frame; sole motion enable.
REQ-004 serve  input  1  one-cycle pulse; launches ball from SERVE_WAIT.
REQ-005 paddle_l_y  input  10  top edge of left paddle, pixels, unsigned.
REQ-006 paddle_r_y  input  10  top edge of right paddle, pixels, unsigned.
REQ-007 ball_x  output  10  top-left x of ball, pixels.
REQ-008 ball_y  output  10  top-left y of ball, pixels.
REQ-009 score_l, score_r  output  4 each  points won by left/right player, 0..9.
REQ-010 point_l, point_r  output  1 each  one-cycle pulse when left/right player scores.
REQ-011 game_over  output  1  high while in GAME_OVER.

Function
REQ-012 Geometry shall be fixed: field 640x480; ball 8x8; paddles 8 wide, 64 tall; left paddle x 16..23; right paddle x 616..623.
REQ-013 States shall be SERVE_WAIT, PLAY, SCORED, GAME_OVER.
REQ-014 Velocity shall be vx, vy each in {-2,+2}, held in signed registers; next position nx=ball_x+vx, ny=ball_y+vy computed in 11-bit signed arithmetic.
REQ-015 Position, velocity, scores and state shall update only in the cycle where frame_tick=1 (registered, visible the following cycle), except serve handling (REQ-021) and reset.
REQ-016 PLAY, y axis: ny<=0 -> ball_y=0, vy=+2; ny>=472 -> ball_y=472, vy=-2; else ball_y=ny.
REQ-017 PLAY, left hit: vx<0, ball_x>=24, nx<=24, and ball_y+8>paddle_l_y and ball_y<paddle_l_y+64 -> ball_x=24, vx=+2; vy=-2 if ball_y+4<paddle_l_y+32, else +2.
REQ-018 PLAY, right hit: vx>0, ball_x<=608, nx>=608, same overlap test with paddle_r_y -> ball_x=608, vx=-2; vy rule as REQ-017.
REQ-019 PLAY, miss: nx<=0 -> point_r pulse, score_r+1, vx=-2 for next serve, go SCORED; nx>=632 -> point_l pulse, score_l+1, vx=+2, go SCORED; else ball_x=nx (no hit).
REQ-020 x and y rules shall apply in the same tick independently (corner hit = wall bounce and paddle bounce together).
REQ-021 SERVE_WAIT: ball held at (316,236); serve=1 -> PLAY next cycle regardless of frame_tick; first movement on next frame_tick after entry.
REQ-022 serve shall be ignored outside SERVE_WAIT.
REQ-023 SCORED: ball placed at (316,236); hold counter counts 60 frame_ticks, then GAME_OVER if either score =9, else SERVE_WAIT.
REQ-024 Scores shall saturate at 9; GAME_OVER shall persist until reset, game_over=1, ball held at (316,236).
REQ-025 point_l/point_r shall be high for exactly one clk cycle, coincident with the score register update.

Reset
REQ-026 On reset=1 at a clock edge: state=SERVE_WAIT, ball=(316,236), vx=+2, vy=+2, scores=0, point pulses=0, game_over=0, hold counter=0; applies from any state, including mid-PLAY and during SCORED hold.
REQ-027 reset shall take priority over frame_tick and serve in the same cycle.

Structure
REQ-028 Package pong_pkg shall hold field size, ball size, paddle geometry, centre coordinates, speed magnitude, hold count (60), winning score (9) and the state enum; paddle block shall share it.
REQ-029 One sub-module, score_counter (4-bit saturating counter with increment and sync reset), shall be instantiated twice.

Verification
REQ-030 Reset then serve, 1 frame_tick -> ball (318,238); vx=+2, vy=+2.
REQ-031 ball_y=470, vy=+2, frame_tick -> ball_y=472, vy=-2.
REQ-032 ball_x=26, vx=-2, ball_y=100, paddle_l_y=80, frame_tick -> ball_x=24, vx=+2, vy=-2 (100+4<112).
REQ-033 ball_x=2, vx=-2, paddle_l_y=300, ball_y=100, frame_tick -> point_r one cycle, score_r=1, ball (316,236); after 60 ticks state SERVE_WAIT; serve -> ball moves with vx=-2.
REQ-034 score_l=8, left scores -> score_l=9, after 60 ticks game_over=1; further serve/frame_ticks no change; reset -> all outputs at REQ-026 values next cycle.
